anc_fir_ctrl: RTL
=================

ANC_FIR_CTRL -- requirements
Module: anc_fir_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 300, max cycles waited for FIR done.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ref_valid / ref_data  input  1 / 16 signed  reference-mic sample (Q1.15).
REQ-005 ref_ready  output  1  ref sample accepted on ref_valid&&ref_ready.
REQ-006 err_valid / err_data  input  1 / 16 signed  error-mic sample (Q1.15).
REQ-007 err_ready  output  1  err sample accepted on err_valid&&err_ready.
REQ-008 cfg_bias  input  16 signed  value driven on a_in each run.
REQ-009 cfg_mu_shift  input  4  step size as right-shift of error.
REQ-010 adapt_en  input  1  0 forces weight_adjust to 0.
REQ-011 x_in, a_in, weight_adjust  output  16 signed each  operands to FIR.
REQ-012 fir_go  output  1  one-cycle FIR start pulse.
REQ-013 fir_done / fir_valid / fir_sample  input  1 / 1 / 16 signed  FIR completion and result.
REQ-014 out_valid / out_ready / out_data  output / input / output  1 / 1 / 16 signed  anti-noise sample to DAC path.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 overrun_cnt  output  8  saturating count of dropped input samples.
REQ-017 timeout_flag  output  1  sticky; set on FIR timeout.
REQ-018 clr_status  input  1  synchronous clear of overrun_cnt and timeout_flag.

Function
REQ-019 States: IDLE, GO, WAIT, OUT; all outputs registered.
REQ-020 One-entry buffers ref_buf and err_buf, each with a full flag; ref_ready = !ref_full, err_ready = !err_full, in every state.
REQ-021 IDLE: when both full flags are set (including same-cycle capture), next edge enters GO.
REQ-022 Entering GO: x_in<=ref_buf, a_in<=cfg_bias, weight_adjust<=computed value, fir_go<=1 for exactly one cycle; both full flags cleared at the same edge.
REQ-023 weight_adjust = adapt_en ? sat16(-(err_buf >>> cfg_mu_shift)) : 0; arithmetic shift, negation in 17 bits; -(-32768) saturates to +32767.
REQ-024 x_in, a_in, weight_adjust held constant from GO until the next GO.
REQ-025 GO -> WAIT after one cycle; WAIT counts cycles from 0.
REQ-026 WAIT: fir_done&&fir_valid captures fir_sample into out_data, out_valid<=1, next state OUT.
REQ-027 WAIT: count reaching TIMEOUT without fir_done sets timeout_flag, out_data<=0, out_valid<=1, next state OUT.
REQ-028 OUT: out_valid and out_data held until out_ready; handshake edge drops out_valid, returns to IDLE.
REQ-029 Inputs keep being buffered during GO/WAIT/OUT; the next run starts from IDLE, so one run may queue behind the current one.
REQ-030 ref_valid&&!ref_ready or err_valid&&!err_ready increments overrun_cnt by 1 (by 1 if both same cycle), saturating at 255; dropped sample discarded, buffer unchanged.
REQ-031 clr_status has priority over a same-cycle increment/set: result 0.
REQ-032 fir_done outside WAIT ignored; fir_done without fir_valid in WAIT ignored (keep counting).
REQ-033 Latency: last input accepted at edge N -> fir_go high in cycle N+1 (IDLE, no pending output).

Reset
REQ-034 rst_n low: state IDLE, buffers empty, ref_ready=err_ready=1, fir_go=0, out_valid=0, busy=0, x_in=a_in=weight_adjust=out_data=0, overrun_cnt=0, timeout_flag=0, WAIT counter 0.
REQ-035 Reset mid-run abandons the run; a later fir_done is ignored.

Verification
REQ-036 ref=0x1000, err=0x4000 same cycle, mu_shift=2, adapt_en=1 -> fir_go one cycle later, x_in=0x1000, weight_adjust=0xF000 (-4096).
REQ-037 err=0x8000, mu_shift=0 -> weight_adjust=0x7FFF; adapt_en=0 -> weight_adjust=0.
REQ-038 FIR model returns 0x1234 after 262 cycles, out_ready low 5 cycles -> out_valid held with 0x1234 5 cycles, one transfer, busy falls after.
REQ-039 No fir_done -> at TIMEOUT cycles timeout_flag=1, out_data=0 delivered; clr_status clears flag.
REQ-040 Three ref samples during one run with err idle -> first buffered, two dropped, overrun_cnt=2; 300 drops saturate at 255.
REQ-041 rst_n pulsed during WAIT -> all outputs at reset values, late fir_done produces no out_valid.

Source files
------------

// File: rtl/anc_fir_ctrl.sv
// rtl/anc_fir_ctrl.sv - ANC FIR run controller
// Buffers one ref/err sample pair, launches the FIR, and returns its result (or 0 on timeout).
module anc_fir_ctrl #(
  parameter int TIMEOUT = 300
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ref_valid_i,
  input  logic signed [15:0] ref_data_i,
  output logic               ref_ready_o,
  input  logic               err_valid_i,
  input  logic signed [15:0] err_data_i,
  output logic               err_ready_o,
  input  logic signed [15:0] cfg_bias_i,
  input  logic        [3:0]  cfg_mu_shift_i,
  input  logic               adapt_en_i,
  output logic signed [15:0] x_in_o,
  output logic signed [15:0] a_in_o,
  output logic signed [15:0] weight_adjust_o,
  output logic               fir_go_o,
  input  logic               fir_done_i,
  input  logic               fir_valid_i,
  input  logic signed [15:0] fir_sample_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic signed [15:0] out_data_o,
  output logic               busy_o,
  output logic        [7:0]  overrun_cnt_o,
  output logic               timeout_flag_o,
  input  logic               clr_status_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_GO, S_WAIT, S_OUT} state_t;

  state_t             state_q, state_d;
  logic signed [15:0] ref_buf_q, err_buf_q;
  logic               ref_full_q, err_full_q;
  logic signed [15:0] x_in_q, a_in_q, weight_q;
  logic               fir_go_q;
  logic               out_valid_q;
  logic signed [15:0] out_data_q;
  logic               busy_q;
  logic        [7:0]  overrun_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               ref_acc, err_acc, drop;
  logic               start, wait_hit, wait_to;
  logic signed [15:0] err_shift;
  logic        [16:0] err_neg;
  logic signed [15:0] weight_d;

  always_comb begin
    ref_acc   = ref_valid_i && !ref_full_q;
    err_acc   = err_valid_i && !err_full_q;
    drop      = (ref_valid_i && ref_full_q) || (err_valid_i && err_full_q);
    start     = (state_q == S_IDLE) && ref_full_q && err_full_q;
    wait_hit  = (state_q == S_WAIT) && fir_done_i && fir_valid_i;
    wait_to   = (state_q == S_WAIT) && !wait_hit && (cnt_q == CNT_W'(TIMEOUT - 1));
    // Negate in 17 bits so -(-32768) is visible as +32768 and can be clamped.
    err_shift = err_buf_q >>> cfg_mu_shift_i;
    err_neg   = -{err_shift[15], err_shift};
    weight_d  = 16'sd0;
    if (adapt_en_i) begin
      weight_d = (err_neg == 17'h08000) ? 16'sh7FFF : err_neg[15:0];
    end
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_GO;
      S_GO:    state_d = S_WAIT;
      S_WAIT:  if (wait_hit || wait_to) state_d = S_OUT;
      S_OUT:   if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ref_buf_q   <= '0;
      err_buf_q   <= '0;
      ref_full_q  <= 1'b0;
      err_full_q  <= 1'b0;
      x_in_q      <= '0;
      a_in_q      <= '0;
      weight_q    <= '0;
      fir_go_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= '0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != S_IDLE);
      fir_go_q <= start;

      // A full buffer never accepts, so capture and the GO-edge clear cannot collide.
      if (ref_acc) begin
        ref_buf_q  <= ref_data_i;
        ref_full_q <= 1'b1;
      end else if (start) begin
        ref_full_q <= 1'b0;
      end
      if (err_acc) begin
        err_buf_q  <= err_data_i;
        err_full_q <= 1'b1;
      end else if (start) begin
        err_full_q <= 1'b0;
      end

      if (start) begin
        x_in_q   <= ref_buf_q;
        a_in_q   <= cfg_bias_i;
        weight_q <= weight_d;
        cnt_q    <= '0;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (wait_hit) begin
        out_data_q  <= fir_sample_i;
        out_valid_q <= 1'b1;
      end else if (wait_to) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b1;
      end else if (state_q == S_OUT && out_ready_i) begin
        out_valid_q <= 1'b0;
      end

      if (clr_status_i) begin
        overrun_q <= '0;
      end else if (drop && overrun_q != 8'hFF) begin
        overrun_q <= overrun_q + 8'd1;
      end

      if (clr_status_i) begin
        timeout_q <= 1'b0;
      end else if (wait_to) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign ref_ready_o     = !ref_full_q;
  assign err_ready_o     = !err_full_q;
  assign x_in_o          = x_in_q;
  assign a_in_o          = a_in_q;
  assign weight_adjust_o = weight_q;
  assign fir_go_o        = fir_go_q;
  assign out_valid_o     = out_valid_q;
  assign out_data_o      = out_data_q;
  assign busy_o          = busy_q;
  assign overrun_cnt_o   = overrun_q;
  assign timeout_flag_o  = timeout_q;

endmodule
